// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit time-multiplexed seven-segment driver.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low g,f,e,d,c,b,a patterns for hex 0..F; the dp bit is added by the caller.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern (no decimal point).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit scanned hex display; the shown value only changes at frame boundaries
// so a scan never mixes old and new data.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cs,
    input  logic [31:0] i_data,
    input  logic [7:0]  i_dp,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        o_frame
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      pend_q, pend_d;
    logic [31:0]      disp_q, disp_d;
    logic             boundary_q, boundary_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       sel_q, sel_d;
    logic             frame_q, frame_d;

    logic             digit_end;
    logic             blank;
    logic [3:0]       nibble;
    logic [6:0]       hex_seg;

    always_comb begin
        digit_end  = (cnt_q == CNT_LAST);
        boundary_d = digit_end && (idx_q == 3'(NUM_DIGITS - 1));
        cnt_d      = digit_end ? '0 : cnt_q + 1'b1;
        idx_d      = digit_end ? idx_q + 3'd1 : idx_q;
        pend_d     = cs ? i_data : pend_q;
        disp_d     = disp_q;
        // A write landing on the boundary itself bypasses pend so the newest value wins.
        if (boundary_d) begin
            disp_d = cs ? i_data : pend_q;
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        nibble  = disp_q[{idx_q, 2'b00} +: 4];
        blank   = BLANK_LZ && (idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == 32'd0);
        sel_d   = ~(8'b1 << idx_q);
        seg_d   = blank ? SEG_OFF : {~i_dp[idx_q], hex_seg};
        // Delayed one cycle so the pulse lines up with the first digit-0 output of the frame.
        frame_d = boundary_q;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            disp_q     <= '0;
            boundary_q <= 1'b0;
            seg_q      <= SEG_OFF;
            sel_q      <= 8'hFF;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            boundary_q <= boundary_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
            frame_q    <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_sel   = sel_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: three instances (SCAN_DIV=4, SCAN_DIV=4 with blanking,
// SCAN_DIV=1) share stimulus and are compared every cycle against a timeline model.
module tb_seg7_scan_display;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cs;
    logic [31:0] i_data;
    logic [7:0]  i_dp;
    logic [7:0]  seg_o   [3];
    logic [7:0]  sel_o   [3];
    logic        frame_o [3];

    int checks = 0;
    int errors = 0;
    int fcnt [3];

    always #5 clk_in = ~clk_in;

    seg7_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_sd4 (
        .clk_in(clk_in), .reset(reset), .cs(cs), .i_data(i_data), .i_dp(i_dp),
        .o_seg(seg_o[0]), .o_sel(sel_o[0]), .o_frame(frame_o[0]));
    seg7_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_sd4_lz (
        .clk_in(clk_in), .reset(reset), .cs(cs), .i_data(i_data), .i_dp(i_dp),
        .o_seg(seg_o[1]), .o_sel(sel_o[1]), .o_frame(frame_o[1]));
    seg7_scan_display #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) u_sd1 (
        .clk_in(clk_in), .reset(reset), .cs(cs), .i_data(i_data), .i_dp(i_dp),
        .o_seg(seg_o[2]), .o_sel(sel_o[2]), .o_frame(frame_o[2]));

    // Reference: state is described by the number of edges k since reset release.
    logic [7:0]  hex8 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int          mk     [3];
    logic [31:0] m_pend [3];
    logic [31:0] m_disp [3];
    logic [7:0]  e_seg  [3];
    logic [7:0]  e_sel  [3];
    logic        e_frame[3];

    function automatic int sd_of(input int c);
        return (c == 2) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            mk[c] = 0; m_pend[c] = '0; m_disp[c] = '0;
            e_seg[c] = 8'hFF; e_sel[c] = 8'hFF; e_frame[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int d, sd, frame_len;
        logic [31:0] upper;
        logic [7:0]  hx;
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 3; c++) begin
            sd        = sd_of(c);
            frame_len = 8 * sd;
            d         = (mk[c] / sd) % 8;
            upper     = m_disp[c] >> (4 * d);
            hx        = hex8[upper[3:0]];
            e_sel[c]  = ~(8'b1 << d);
            if (c == 1 && d != 0 && upper == 0) e_seg[c] = 8'hFF;
            else                                e_seg[c] = {~i_dp[d], hx[6:0]};
            e_frame[c] = (mk[c] > 0) && (mk[c] % frame_len == 0);
            if ((mk[c] + 1) % frame_len == 0) m_disp[c] = cs ? i_data : m_pend[c];
            if (cs) m_pend[c] = i_data;
            mk[c]++;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("seg[%0d]", c), {24'd0, seg_o[c]}, {24'd0, e_seg[c]});
            check($sformatf("sel[%0d]", c), {24'd0, sel_o[c]}, {24'd0, e_sel[c]});
            check($sformatf("frame[%0d]", c), {31'd0, frame_o[c]}, {31'd0, e_frame[c]});
            if (frame_o[c] === 1'b1) fcnt[c]++;
        end
    endtask

    typedef struct packed {
        logic [31:0]      data;
        logic [7:0][7:0]  nz;
        logic [7:0][7:0]  lz;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0] exp8;
        int n;

        vecs[0] = {32'h1234ABCD, 64'hF9A4B099_8883C6A1, 64'hF9A4B099_8883C6A1};
        vecs[1] = {32'h00000A05, 64'hC0C0C0C0_C088C092, 64'hFFFFFFFF_FF88C092};
        vecs[2] = {32'h00000000, 64'hC0C0C0C0_C0C0C0C0, 64'hFFFFFFFF_FFFFFFC0};
        vecs[3] = {32'h80000001, 64'h80C0C0C0_C0C0C0F9, 64'h80C0C0C0_C0C0C0F9};
        vecs[4] = {32'h0000F000, 64'hC0C0C0C0_8EC0C0C0, 64'hFFFFFFFF_8EC0C0C0};

        reset = 1'b1; cs = 1'b0; i_data = '0; i_dp = '0;
        model_reset();
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) fcnt[c] = 0;

        // First edge after release, then the select walk and frame pulse rate.
        tick();
        check("first_sel", {24'd0, sel_o[0]}, 32'hFE);
        check("first_seg", {24'd0, seg_o[0]}, 32'hC0);
        for (int d = 1; d < 8; d++) begin
            repeat (4) tick();
            exp8 = ~(8'b1 << d);
            check($sformatf("walk_sel%0d", d), {24'd0, sel_o[0]}, {24'd0, exp8});
        end
        repeat (51) tick();
        check("frames_sd4", fcnt[0], 2);
        check("frames_sd4_lz", fcnt[1], 2);
        check("frames_sd1", fcnt[2], 9);

        // Write during a frame; the next frame must show every digit of the new value.
        for (int v = 0; v < 5; v++) begin
            cs = 1'b1; i_data = vecs[v].data;
            tick();
            cs = 1'b0; i_data = '0;
            n = 0;
            do begin
                tick(); n++;
            end while (frame_o[0] !== 1'b1 && n < 100);
            check($sformatf("frame_wait%0d", v), {31'd0, frame_o[0]}, 32'd1);
            for (int d = 0; d < 8; d++) begin
                if (d > 0) repeat (4) tick();
                exp8 = ~(8'b1 << d);
                check($sformatf("tab%0d_sel%0d", v, d), {24'd0, sel_o[0]}, {24'd0, exp8});
                check($sformatf("tab%0d_nz%0d", v, d), {24'd0, seg_o[0]}, {24'd0, vecs[v].nz[d]});
                check($sformatf("tab%0d_lz%0d", v, d), {24'd0, seg_o[1]}, {24'd0, vecs[v].lz[d]});
            end
        end

        // Write exactly on the boundary edge with a different value already pending.
        cs = 1'b1; i_data = 32'hF;
        tick();
        cs = 1'b0; i_data = '0;
        n = 0;
        while ((mk[0] % 32) != 31 && n < 64) begin
            tick(); n++;
        end
        cs = 1'b1; i_data = 32'h8;
        tick();
        cs = 1'b0; i_data = '0;
        tick();
        check("coinc_sel", {24'd0, sel_o[0]}, 32'hFE);
        check("coinc_seg", {24'd0, seg_o[0]}, 32'h80);
        check("coinc_frame", {31'd0, frame_o[0]}, 32'd1);

        // Decimal point on digit 0 with disp=0, toggled mid-digit.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_dp = 8'h01;
        tick();
        check("dp_on", {24'd0, seg_o[0]}, 32'h40);
        i_dp = 8'h00;
        tick();
        check("dp_off", {24'd0, seg_o[0]}, 32'hC0);
        i_dp = 8'h01;
        repeat (4) tick();
        check("dp_other_digit", {24'd0, seg_o[0]}, 32'hC0);

        // Random traffic with occasional asynchronous reset mid-scan.
        for (int i = 0; i < 1500; i++) begin
            cs     = ($urandom_range(0, 7) == 0);
            i_data = $urandom;
            i_dp   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) i_data = i_data >> (4 * $urandom_range(1, 7));
            tick();
            if (i % 500 == 250) begin
                #2 reset = 1'b1;
                #1;
                for (int c = 0; c < 3; c++) begin
                    check($sformatf("async_seg[%0d]", c), {24'd0, seg_o[c]}, 32'hFF);
                    check($sformatf("async_sel[%0d]", c), {24'd0, sel_o[c]}, 32'hFF);
                    check($sformatf("async_frame[%0d]", c), {31'd0, frame_o[c]}, 32'd0);
                end
                cs = 1'b1; i_data = 32'hDEADBEEF;
                tick(); tick();
                cs = 1'b0;
                reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
